// File: rtl/watch_set_ctrl.sv
// rtl/watch_set_ctrl.sv - 24h watch timekeeper with button-driven time-set FSM
// Optional idle auto-exit from set mode: define WATCH_SET_TIMEOUT_EN.
module watch_set_ctrl #(
   parameter int TICK_DIV      = 1_000_000,
   parameter int INIT_HOUR     = 12,
   parameter int TIMEOUT_TICKS = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_mode,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic [23:0] o_w_time,
   output logic [1:0]  o_w_state,
   output logic        o_tick
);

   localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   localparam logic [1:0] ST_RUN      = 2'b00;
   localparam logic [1:0] ST_SET_HOUR = 2'b01;
   localparam logic [1:0] ST_SET_MIN  = 2'b10;
   localparam logic [1:0] ST_SET_SEC  = 2'b11;

   logic [2:0]       r_btn_q;
   logic [2:0]       r_btn_q2;
   logic [2:0]       w_btn_edge;
   logic             w_mode_e;
   logic             w_up_e;
   logic             w_down_e;
   logic             w_adj_up;
   logic             w_adj_dn;
   logic             w_tick;
   logic             w_timeout;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic             r_tick;

   logic [4:0]       r_hour;
   logic [5:0]       r_min;
   logic [5:0]       r_sec;
   logic [6:0]       r_msec;

   // Modulo step used by the set-mode adjust; never carries into neighbours.
   function automatic logic [5:0] f_step(input logic [5:0] v, input logic [5:0] max_v,
                                         input logic up);
      if (up) f_step = (v == max_v) ? 6'd0 : v + 6'd1;
      else    f_step = (v == 6'd0) ? max_v : v - 6'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_btn_q  <= '0;
         r_btn_q2 <= '0;
      end else begin
         r_btn_q  <= {btn_mode, btn_up, btn_down};
         r_btn_q2 <= r_btn_q;
      end
   end

   assign w_btn_edge = r_btn_q & ~r_btn_q2;
   assign w_mode_e   = w_btn_edge[2];
   assign w_up_e     = w_btn_edge[1];
   assign w_down_e   = w_btn_edge[0];
   assign w_adj_up   = w_up_e & ~w_down_e & ~w_mode_e;
   assign w_adj_dn   = w_down_e & ~w_up_e & ~w_mode_e;
   assign w_tick     = (r_state == ST_RUN) && !w_mode_e && (r_div == DIV_LAST);

`ifdef WATCH_SET_TIMEOUT_EN
   logic [DIV_W-1:0] r_idle_div;
   logic [31:0]      r_idle_cnt;

   // The main divider is frozen in set mode, so idle time uses its own prescaler.
   always_ff @(posedge clk) begin
      if (reset || (r_state == ST_RUN) || (|w_btn_edge)) begin
         r_idle_div <= '0;
         r_idle_cnt <= '0;
      end else if (r_idle_div == DIV_LAST) begin
         r_idle_div <= '0;
         if (r_idle_cnt < 32'(TIMEOUT_TICKS)) r_idle_cnt <= r_idle_cnt + 32'd1;
      end else begin
         r_idle_div <= r_idle_div + 1'b1;
      end
   end

   assign w_timeout = (r_idle_cnt >= 32'(TIMEOUT_TICKS)) && !(|w_btn_edge);
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (w_mode_e)
         w_state_nxt = r_state + 2'd1;
      else if (w_timeout && (r_state != ST_RUN))
         w_state_nxt = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else if ((r_state != ST_RUN) || w_mode_e) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else if (r_div == DIV_LAST) begin
         r_div  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_div  <= r_div + 1'b1;
         r_tick <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hour <= 5'(INIT_HOUR);
         r_min  <= '0;
         r_sec  <= '0;
         r_msec <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_mode_e) begin
            r_msec <= '0;
         end else if (w_tick) begin
            if (r_msec == 7'd99) begin
               r_msec <= '0;
               if (r_sec == 6'd59) begin
                  r_sec <= '0;
                  if (r_min == 6'd59) begin
                     r_min  <= '0;
                     r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                  end else begin
                     r_min <= r_min + 6'd1;
                  end
               end else begin
                  r_sec <= r_sec + 6'd1;
               end
            end else begin
               r_msec <= r_msec + 7'd1;
            end
         end
      end else if (w_adj_up || w_adj_dn) begin
         case (r_state)
            ST_SET_HOUR: r_hour <= 5'(f_step({1'b0, r_hour}, 6'd23, w_adj_up));
            ST_SET_MIN:  r_min  <= f_step(r_min, 6'd59, w_adj_up);
            ST_SET_SEC:  r_sec  <= f_step(r_sec, 6'd59, w_adj_up);
            default:     r_msec <= r_msec;
         endcase
      end
   end

   assign o_w_time  = {r_hour, r_min, r_sec, r_msec};
   assign o_w_state = r_state;
   assign o_tick    = r_tick;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb/tb_watch_set_ctrl.sv - directed self-checking bench for watch_set_ctrl
module tb_watch_set_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_mode = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic [23:0] o_w_time;
   logic [1:0]  o_w_state;
   logic        o_tick;

   int n_cmp = 0;
   int n_err = 0;
   int n_ticks;

   watch_set_ctrl #(
      .TICK_DIV      (4),
      .INIT_HOUR     (12),
      .TIMEOUT_TICKS (3)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .btn_mode  (btn_mode),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .o_w_time  (o_w_time),
      .o_w_state (o_w_state),
      .o_tick    (o_tick)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] tw(input int h, input int m, input int s, input int ms);
      tw = {5'(h), 6'(m), 6'(s), 7'(ms)};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Rising edge on the chosen buttons; the action is visible on return.
   task automatic pulse(input logic m, input logic u, input logic d);
      btn_mode = m;
      btn_up   = u;
      btn_down = d;
      step(1);
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      step(1);
   endtask

   initial begin
      step(2);
      check_val("rst_time", 32'(o_w_time), 32'(tw(12, 0, 0, 0)));
      check_val("rst_state", 32'(o_w_state), 32'd0);
      check_val("rst_tick", 32'(o_tick), 32'd0);
      reset = 1'b0;

      n_ticks = 0;
      for (int i = 0; i < 400; i++) begin
         step(1);
         if (o_tick) n_ticks++;
         if (i == 2) check_val("tick_c3", 32'(o_tick), 32'd0);
         if (i == 3) check_val("tick_c4", 32'(o_tick), 32'd1);
         if (i == 4) check_val("tick_c5", 32'(o_tick), 32'd0);
      end
      check_val("run400_ticks", 32'(n_ticks), 32'd100);
      check_val("run400_time", 32'(o_w_time), 32'(tw(12, 0, 1, 0)));
      check_val("run400_state", 32'(o_w_state), 32'd0);

      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(148);
      check_val("run_37", 32'(o_w_time), 32'(tw(12, 0, 0, 37)));
      pulse(1, 0, 0);
      check_val("enter_hour_state", 32'(o_w_state), 32'd1);
      check_val("enter_hour_msec0", 32'(o_w_time), 32'(tw(12, 0, 0, 0)));
      for (int i = 0; i < 13; i++) pulse(0, 0, 1);
      check_val("hour_down13", 32'(o_w_time), 32'(tw(23, 0, 0, 0)));
      n_ticks = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (o_tick) n_ticks++;
      end
      check_val("frozen_time", 32'(o_w_time), 32'(tw(23, 0, 0, 0)));
      check_val("frozen_state", 32'(o_w_state), 32'd1);
      check_val("frozen_ticks", 32'(n_ticks), 32'd0);
      pulse(0, 1, 0);
      check_val("hour_up_wrap", 32'(o_w_time), 32'(tw(0, 0, 0, 0)));
      pulse(0, 0, 1);
      check_val("hour_dn_wrap", 32'(o_w_time), 32'(tw(23, 0, 0, 0)));

      pulse(1, 0, 0);
      check_val("set_min_state", 32'(o_w_state), 32'd2);
      pulse(0, 0, 1);
      check_val("min_dn_wrap", 32'(o_w_time), 32'(tw(23, 59, 0, 0)));
      pulse(0, 1, 0);
      check_val("min_up_wrap", 32'(o_w_time), 32'(tw(23, 0, 0, 0)));
      pulse(0, 1, 1);
      check_val("min_up_dn", 32'(o_w_time), 32'(tw(23, 0, 0, 0)));
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      check_val("set_sec_state", 32'(o_w_state), 32'd3);
      pulse(0, 0, 1);
      check_val("sec_dn_wrap", 32'(o_w_time), 32'(tw(23, 59, 59, 0)));
      pulse(1, 0, 0);
      check_val("exit_state", 32'(o_w_state), 32'd0);
      step(396);
      check_val("pre_wrap", 32'(o_w_time), 32'(tw(23, 59, 59, 99)));
      step(3);
      check_val("pre_wrap_hold", 32'(o_w_time), 32'(tw(23, 59, 59, 99)));
      step(1);
      check_val("day_wrap", 32'(o_w_time), 32'(tw(0, 0, 0, 0)));
      check_val("day_wrap_tick", 32'(o_tick), 32'd1);

      pulse(1, 0, 0);
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      for (int i = 0; i < 5; i++) pulse(0, 1, 0);
      check_val("sec_up5", 32'(o_w_time), 32'(tw(0, 0, 5, 0)));
      pulse(1, 1, 0);
      check_val("mode_up_state", 32'(o_w_state), 32'd0);
      check_val("mode_up_time", 32'(o_w_time), 32'(tw(0, 0, 5, 0)));

      pulse(1, 0, 0);
      btn_up = 1'b1;
      step(50);
      btn_up = 1'b0;
      step(2);
      check_val("held_up_once", 32'(o_w_time), 32'(tw(1, 0, 5, 0)));

      pulse(1, 0, 0);
      check_val("pre_rst_state", 32'(o_w_state), 32'd2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_val("mid_rst_time", 32'(o_w_time), 32'(tw(12, 0, 0, 0)));
      check_val("mid_rst_state", 32'(o_w_state), 32'd0);

      step(2);
      btn_mode = 1'b1;
      step(1);
      btn_mode = 1'b0;
      step(1);
      check_val("coinc_state", 32'(o_w_state), 32'd1);
      check_val("coinc_time", 32'(o_w_time), 32'(tw(12, 0, 0, 0)));
      check_val("coinc_tick", 32'(o_tick), 32'd0);

      step(20);
`ifdef WATCH_SET_TIMEOUT_EN
      check_val("idle_state", 32'(o_w_state), 32'd0);
`else
      check_val("idle_state", 32'(o_w_state), 32'd1);
`endif
      check_val("idle_time", 32'(o_w_time[23:7]), 32'(tw(12, 0, 0, 0) >> 7));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
